// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: FSM state encoding and default constants for serial_rx.
// PARITY exists only when SERIAL_RX_PARITY_EN is defined.
package serial_rx_pkg;

   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef SERIAL_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

endpackage

// File: rtl/rx_sync_2ff.sv
// rx_sync_2ff: two-flop synchronizer; resets to 1 so the idle line never looks like a start bit.
module rx_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) {q, s1_q} <= 2'b11;
      else     {q, s1_q} <= {s1_q, d};

endmodule

// File: rtl/serial_rx.sv
// serial_rx: UART-style receiver with ready/valid output and error/overrun pulses.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between data and stop.
module serial_rx
   import serial_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
`ifdef SERIAL_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
   logic                 rxd_s, rxd_prev_q, par_bad;

   rx_sync_2ff u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxd_s));

`ifdef SERIAL_RX_PARITY_EN
   logic par_q, par_d;
   assign par_bad = ^{shift_q, par_q};
   always_ff @(posedge clk or posedge rst)
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
`else
   assign par_bad = 1'b0;
`endif

   // Counter restarts at mid-start, so every later FULL lands mid-bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q & ~rx_ready;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      ovr_d   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rxd_prev_q & ~rxd_s) state_d = START;
         end
         START:
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rxd_s ? IDLE : DATA;
            end
         DATA:
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST) state_d = AFTER_DATA;
            end
`ifdef SERIAL_RX_PARITY_EN
         PARITY:
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               par_d   = rxd_s;
               state_d = STOP;
            end
`endif
         STOP:
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               state_d = rxd_s ? IDLE : WAIT_IDLE;
               if (!rxd_s) ferr_d = 1'b1;
               else if (par_bad) perr_d = 1'b1;
               else if (valid_q & ~rx_ready) ovr_d = 1'b1;
               else begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
            end
         WAIT_IDLE: begin
            cnt_d = '0;
            if (rxd_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         rxd_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         ovr_q      <= ovr_d;
         rxd_prev_q <= rxd_s;
      end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx; frame outcomes predicted from line-level rules.
module tb_serial_rx;

   localparam int CPB = 16;
   localparam logic [1:0] K_DATA = 2'd0, K_FERR = 2'd1, K_PERR = 2'd2, K_OVR = 2'd3;
`ifdef SERIAL_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, overrun, busy;
   int         n_vec = 0, n_bad = 0;
   bit         model_full = 1'b0;
   ev_t        exp_q[$];
   logic       pv = 1'b0, pr = 1'b0;

   serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic got(input logic [1:0] k, input logic [7:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d data %0h want none", k, d);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 32'(k), 32'(e.kind));
         if (e.kind == K_DATA) chk("rx_data", 32'(d), 32'(e.data));
      end
   endtask

   // New word = valid now, and last cycle either empty or transferred.
   always @(negedge clk) begin
      if (rst) begin
         pv <= 1'b0;
         pr <= 1'b0;
      end else begin
         if (frame_err)  got(K_FERR, 8'h00);
         if (parity_err) got(K_PERR, 8'h00);
         if (overrun)    got(K_OVR, 8'h00);
         if (rx_valid && (!pv || pr)) got(K_DATA, rx_data);
         pv <= rx_valid;
         pr <= rx_ready;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ready(input logic v);
      rx_ready = v;
      if (v) model_full = 1'b0;
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic stop, input logic pflip);
      ev_t e;
      e.data = d;
      if (!stop) e.kind = K_FERR;
      else if (pflip && PAR_EN) e.kind = K_PERR;
      else if (model_full && !rx_ready) e.kind = K_OVR;
      else begin
         e.kind = K_DATA;
         if (!rx_ready) model_full = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
      expect_frame(d, stop, pflip);
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         tick(CPB);
      end
      if (PAR_EN) begin
         rxd = (^d) ^ pflip;
         tick(CPB);
      end
      rxd = stop;
      tick(CPB);
      if (!stop) chk("busy_wait_idle", 32'(busy), 32'd1);
      rxd = 1'b1;
      tick(8);
      chk("busy_after_frame", 32'(busy), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
      chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] bits3;
      tick(2);
      chk_all_zero("reset");
      rst = 1'b0;
      tick(4);

      send_frame(8'hA5, 1'b1, 1'b0);

      rxd = 1'b0;
      tick(4);
      chk("false_start_busy", 32'(busy), 32'd1);
      rxd = 1'b1;
      tick(20);
      chk("false_start_idle", 32'(busy), 32'd0);
      chk("false_start_valid", 32'(rx_valid), 32'd0);

      send_frame(8'h3C, 1'b0, 1'b0);
      chk("ferr_no_valid", 32'(rx_valid), 32'd0);
      send_frame(8'h11, 1'b1, 1'b0);

      set_ready(1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0);
      chk("overrun_data_kept", 32'(rx_data), 32'h3C);
      chk("overrun_valid_held", 32'(rx_valid), 32'd1);
      set_ready(1'b1);
      tick(1);
      chk("transfer_clears_valid", 32'(rx_valid), 32'd0);
      chk("transfer_data_holds", 32'(rx_data), 32'h3C);

      if (PAR_EN) begin
         send_frame(8'h01, 1'b1, 1'b1);
         chk("perr_no_valid", 32'(rx_valid), 32'd0);
         send_frame(8'h01, 1'b1, 1'b0);
      end

      set_ready(1'b0);
      send_frame(8'h77, 1'b1, 1'b0);
      rxd = 1'b0;
      tick(CPB);
      bits3 = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         rxd = bits3[i];
         tick(CPB);
      end
      rst = 1'b1;
      rxd = 1'b1;
      #1;
      chk_all_zero("midframe_reset");
      model_full = 1'b0;
      tick(3);
      rst = 1'b0;
      set_ready(1'b1);
      tick(4);
      send_frame(8'h5A, 1'b1, 1'b0);

      for (int n = 0; n < 30; n++) begin
         set_ready(1'($urandom_range(0, 1)));
         send_frame(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
      end
      set_ready(1'b1);

      tick(40);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
